// File: rtl/if_fetch_buf_pkg.sv
// rtl/if_fetch_buf_pkg.sv - shared widths, reset address and PC helper for the fetch buffer
package if_fetch_buf_pkg;

  localparam int XLEN         = 64;
  localparam int INST_LEN     = 32;
  localparam int FIFO_ENTRIES = 2;
  localparam int CNT_W        = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 64'h8000_0000;

  // Jump targets are forced onto a 4-byte instruction boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/if_fifo2.sv
// rtl/if_fifo2.sv - two-entry FIFO with flush, shared by the pending-PC queue and the ID buffer
module if_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic [1:0]   count_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  // An empty FIFO presents zeros so the head never leaks stale entries.
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/if_fetch_buf.sv
// rtl/if_fetch_buf.sv - instruction fetch with in-order request tracking, redirect drop and ID buffer
module if_fetch_buf
  import if_fetch_buf_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect_i,
  input  logic [XLEN-1:0]     redirect_pc_i,
  output logic                imem_req_valid_o,
  input  logic                imem_req_ready_i,
  output logic [XLEN-1:0]     imem_req_addr_o,
  input  logic                imem_rsp_valid_i,
  input  logic [INST_LEN-1:0] imem_rsp_data_i,
  output logic                id_valid_o,
  input  logic                id_ready_i,
  output logic [XLEN-1:0]     id_pc_o,
  output logic [INST_LEN-1:0] id_instr_o
);

  localparam int CAP = (DEPTH < FIFO_ENTRIES) ? DEPTH : FIFO_ENTRIES;

  logic [XLEN-1:0]          fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]         drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]         outstanding;
  logic [CNT_W-1:0]         occupancy;
  logic                     req_fire, id_fire;
  logic                     rsp_owned, rsp_drop;
  logic                     pend_pop, out_push;
  logic [XLEN-1:0]          pend_pc;
  logic [1:0]               pend_count, out_count;
  logic                     pend_full, pend_empty, out_full, out_empty;
  logic [XLEN+INST_LEN-1:0] out_head;

  // Requests still owed a response, including those already marked for dropping.
  assign outstanding = CNT_W'(pend_count) + drop_cnt_q;
  // An entry leaving for ID this cycle frees its slot for a same-cycle request.
  assign occupancy   = outstanding + CNT_W'(out_count) - CNT_W'(id_fire);

  assign imem_req_valid_o = !rst && !redirect_i && (occupancy < CNT_W'(CAP));
  assign imem_req_addr_o  = fetch_pc_q;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;

  assign rsp_owned = imem_rsp_valid_i && (outstanding != '0);
  assign rsp_drop  = rsp_owned && (drop_cnt_q != '0);
  assign pend_pop  = rsp_owned && !rsp_drop;
  assign out_push  = pend_pop && !redirect_i;

  assign id_valid_o = !rst && !redirect_i && !out_empty;
  assign id_fire    = id_valid_o && id_ready_i;
  assign id_pc_o    = out_head[XLEN+INST_LEN-1:INST_LEN];
  assign id_instr_o = out_head[INST_LEN-1:0];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_i) begin
      fetch_pc_d = align_pc(redirect_pc_i);
      drop_cnt_d = outstanding - CNT_W'(rsp_owned);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (rsp_drop) drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  if_fifo2 #(.W(XLEN)) u_pend_q (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_i),
    .push_i  (req_fire),
    .pop_i   (pend_pop),
    .data_i  (fetch_pc_q),
    .data_o  (pend_pc),
    .count_o (pend_count),
    .full_o  (pend_full),
    .empty_o (pend_empty)
  );

  if_fifo2 #(.W(XLEN + INST_LEN)) u_out_q (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_i),
    .push_i  (out_push),
    .pop_i   (id_fire),
    .data_i  ({pend_pc, imem_rsp_data_i}),
    .data_o  (out_head),
    .count_o (out_count),
    .full_o  (out_full),
    .empty_o (out_empty)
  );

  rsp_has_owner: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid_i |-> (outstanding != '0));
  pend_pop_nonempty: assert property (@(posedge clk) disable iff (rst)
    pend_pop |-> !pend_empty);
  pend_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(req_fire && pend_full && !pend_pop));
  out_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(out_push && out_full && !id_fire));

endmodule

// File: tb/tb_if_fetch_buf.sv
// tb/tb_if_fetch_buf.sv - directed scoreboard bench for if_fetch_buf with a queued memory model
module tb_if_fetch_buf;
  import if_fetch_buf_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                redirect_i = 1'b0;
  logic [XLEN-1:0]     redirect_pc_i = '0;
  logic                imem_req_valid_o;
  logic                imem_req_ready_i = 1'b1;
  logic [XLEN-1:0]     imem_req_addr_o;
  logic                imem_rsp_valid_i = 1'b0;
  logic [INST_LEN-1:0] imem_rsp_data_i = '0;
  logic                id_valid_o;
  logic                id_ready_i = 1'b1;
  logic [XLEN-1:0]     id_pc_o;
  logic [INST_LEN-1:0] id_instr_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [XLEN-1:0] sb_q[$];
  logic [XLEN-1:0] mem_q[$];
  logic [XLEN-1:0] exp_pc;
  logic            smp_rst  = 1'b1;
  logic            smp_fire = 1'b0;
  logic [XLEN-1:0] smp_addr = '0;

  if_fetch_buf dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .id_valid_o       (id_valid_o),
    .id_ready_i       (id_ready_i),
    .id_pc_o          (id_pc_o),
    .id_instr_o       (id_instr_o)
  );

  always #5 clk = ~clk;

  function automatic logic [INST_LEN-1:0] instr_of(input logic [XLEN-1:0] a);
    return a[INST_LEN-1:0] ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic push_seq(input logic [XLEN-1:0] base, input int n);
    for (int k = 0; k < n; k++) sb_q.push_back(base + XLEN'(4 * k));
  endtask

  // One cycle: memory answers requests seen last cycle (unless held), then inputs change.
  task automatic drive(input logic r, input logic hold, input logic rd,
                       input logic [XLEN-1:0] rpc, input logic idr);
    @(posedge clk);
    #1;
    if (smp_rst) begin
      mem_q.delete();
      imem_rsp_valid_i = 1'b0;
    end else begin
      if (smp_fire) mem_q.push_back(smp_addr);
      if (!hold && mem_q.size() != 0) begin
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = instr_of(mem_q.pop_front());
      end else begin
        imem_rsp_valid_i = 1'b0;
      end
    end
    rst           = r;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    id_ready_i    = idr;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    smp_rst  = rst;
    smp_fire = (imem_req_valid_o === 1'b1) && imem_req_ready_i;
    smp_addr = imem_req_addr_o;
    if (id_valid_o === 1'b1 && id_ready_i) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL id_extra: got pc %h, required no instruction", id_pc_o);
      end else begin
        exp_pc = sb_q.pop_front();
        check("id_pc", id_pc_o, exp_pc);
        check("id_instr", XLEN'(id_instr_o), XLEN'(instr_of(exp_pc)));
      end
    end
  end

  initial begin
    drive(1, 0, 0, '0, 1);
    drive(1, 0, 0, '0, 1);
    check("rst_req_valid", XLEN'(imem_req_valid_o), 0);
    check("rst_id_valid", XLEN'(id_valid_o), 0);
    check("rst_id_pc", id_pc_o, 0);
    check("rst_id_instr", XLEN'(id_instr_o), 0);
    check("rst_fetch_addr", imem_req_addr_o, 64'h8000_0000);

    // Streaming: back-to-back fetches, first ID instruction on the third cycle.
    push_seq(64'h8000_0000, 10);
    drive(0, 0, 0, '0, 1);
    check("c0_req_valid", XLEN'(imem_req_valid_o), 1);
    check("c0_addr", imem_req_addr_o, 64'h8000_0000);
    drive(0, 0, 0, '0, 1);
    check("c1_id_valid", XLEN'(id_valid_o), 0);
    check("c1_addr", imem_req_addr_o, 64'h8000_0004);
    drive(0, 0, 0, '0, 1);
    check("c2_id_valid", XLEN'(id_valid_o), 1);
    repeat (5) drive(0, 0, 0, '0, 1);

    // ID stall: buffer fills, fetch stops, nothing lost.
    drive(0, 0, 0, '0, 0);
    drive(0, 0, 0, '0, 0);
    drive(0, 0, 0, '0, 0);
    check("stall_req_valid", XLEN'(imem_req_valid_o), 0);
    check("stall_id_valid", XLEN'(id_valid_o), 1);
    check("stall_id_pc", id_pc_o, 64'h8000_0018);
    drive(0, 0, 0, '0, 0);
    drive(0, 0, 0, '0, 0);
    repeat (3) drive(0, 0, 0, '0, 1);

    // Redirect with two requests in flight: both responses must be dropped.
    drive(0, 1, 0, '0, 1);
    push_seq(64'h8000_0100, 3);
    drive(0, 1, 1, 64'h8000_0100, 1);
    check("redir_req_valid", XLEN'(imem_req_valid_o), 0);
    drive(0, 0, 0, '0, 1);
    check("drop_holds_slot", XLEN'(imem_req_valid_o), 0);
    drive(0, 0, 0, '0, 1);
    check("redir_req_valid2", XLEN'(imem_req_valid_o), 1);
    check("redir_addr", imem_req_addr_o, 64'h8000_0100);
    repeat (4) drive(0, 0, 0, '0, 1);

    // Misaligned target is rounded down to a word boundary.
    push_seq(64'h8000_0100, 2);
    drive(0, 0, 1, 64'h8000_0103, 1);
    drive(0, 0, 0, '0, 1);
    check("align_req_valid", XLEN'(imem_req_valid_o), 1);
    check("align_addr", imem_req_addr_o, 64'h8000_0100);
    repeat (3) drive(0, 0, 0, '0, 1);

    // Back-to-back redirects with a held response: the last target wins.
    push_seq(64'h8000_0300, 3);
    drive(0, 1, 1, 64'h8000_0200, 1);
    drive(0, 1, 1, 64'h8000_0300, 1);
    drive(0, 0, 0, '0, 1);
    check("dbl_req_valid", XLEN'(imem_req_valid_o), 1);
    check("dbl_addr", imem_req_addr_o, 64'h8000_0300);
    repeat (4) drive(0, 0, 0, '0, 1);

    // Mid-operation reset with a buffered entry and a response landing in the reset cycle.
    push_seq(64'h8000_0000, 5);
    drive(1, 0, 0, '0, 1);
    drive(1, 0, 0, '0, 1);
    check("mrst_req_valid", XLEN'(imem_req_valid_o), 0);
    check("mrst_id_valid", XLEN'(id_valid_o), 0);
    check("mrst_id_pc", id_pc_o, 0);
    check("mrst_id_instr", XLEN'(id_instr_o), 0);
    drive(0, 0, 0, '0, 1);
    check("mrst_req_valid2", XLEN'(imem_req_valid_o), 1);
    check("mrst_addr", imem_req_addr_o, 64'h8000_0000);
    repeat (6) drive(0, 0, 0, '0, 1);
    repeat (4) drive(0, 0, 0, '0, 0);

    check("sb_drained", XLEN'(sb_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
